// File: rtl/hvgen_param_if.sv
// Video timing output bundle for hvgen_param.
// The generator drives it through the master modport; consumers use the slave modport.
interface hvgen_param_if #(
    parameter int HCNT_W = 9,
    parameter int VCNT_W = 8
);
    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic              hb;
    logic              vb;
    logic              hs;
    logic              vs;
    logic              de;
    logic [23:0]       rgb_out;
    logic              line_start;
    logic              frame_start;

    modport master (
        output hcnt, vcnt, hb, vb, hs, vs, de,
        output rgb_out, line_start, frame_start
    );

    modport slave (
        input hcnt, vcnt, hb, vb, hs, vs, de,
        input rgb_out, line_start, frame_start
    );
endinterface

// File: rtl/hvgen_param.sv
// Parameterised raster timing generator with crop, sync shift and blanking.
// Flags are decoded from the next counter value so they line up with hcnt/vcnt.
module hvgen_param #(
    parameter int H_TOTAL      = 318,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 283,
    parameter int H_SYNC_END   = 303,
    parameter int V_TOTAL      = 256,
    parameter int V_ACTIVE     = 240,
    parameter int V_SYNC_START = 252,
    parameter int V_SYNC_END   = 255,
    parameter int HCNT_W       = 9,
    parameter int VCNT_W       = 8
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ce_pix,
    input  logic [3:0]          crop_left,
    input  logic [3:0]          h_shift,
    input  logic [23:0]         rgb_in,
    hvgen_param_if.master       vid
);

    if (H_SYNC_END + 7 >= H_TOTAL || H_SYNC_START - 8 < H_ACTIVE ||
        H_SYNC_START >= H_SYNC_END || V_SYNC_START >= V_SYNC_END) begin : g_bad_params
        $error("hvgen_param: illegal sync timing parameters");
    end

    localparam int SW = HCNT_W + 1;

    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ACT  = HCNT_W'(H_ACTIVE);
    localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_ACT  = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] V_SS   = VCNT_W'(V_SYNC_START);
    localparam logic [VCNT_W-1:0] V_SE   = VCNT_W'(V_SYNC_END);

    localparam logic signed [SW-1:0] HS_S = SW'(H_SYNC_START);
    localparam logic signed [SW-1:0] HS_E = SW'(H_SYNC_END);

    logic [HCNT_W-1:0]    hcnt_q, hcnt_d;
    logic [VCNT_W-1:0]    vcnt_q, vcnt_d;
    logic [3:0]           crop_q, crop_d;
    logic signed [SW-1:0] shift_q, shift_d;
    logic                 hb_q, hb_d;
    logic                 vb_q, vb_d;
    logic                 hs_q, hs_d;
    logic                 vs_q, vs_d;
    logic                 de_q, de_d;
    logic [23:0]          rgb_q, rgb_d;
    logic                 line_start_q, line_start_d;
    logic                 frame_start_q, frame_start_d;

    logic                 h_wrap;
    logic [HCNT_W-1:0]    h_nx;
    logic [VCNT_W-1:0]    v_nx;
    logic                 frame_nx;
    logic [3:0]           crop_nx;
    logic signed [SW-1:0] shift_nx;
    logic signed [SW-1:0] h_s;
    logic                 hb_nx;
    logic                 vb_nx;
    logic                 hs_nx;
    logic                 de_nx;

    always_comb begin
        h_wrap   = (hcnt_q == H_LAST);
        h_nx     = h_wrap ? '0 : hcnt_q + HCNT_W'(1);
        v_nx     = vcnt_q;
        if (h_wrap) begin
            v_nx = (vcnt_q == V_LAST) ? '0 : vcnt_q + VCNT_W'(1);
        end
        frame_nx = (h_nx == '0) && (v_nx == '0);

        // Shadow values take effect on the very edge that starts the new frame.
        crop_nx  = frame_nx ? crop_left : crop_q;
        shift_nx = frame_nx ? {{(SW-4){h_shift[3]}}, h_shift} : shift_q;

        h_s   = {1'b0, h_nx};
        hb_nx = (h_nx < HCNT_W'(crop_nx)) || (h_nx >= H_ACT);
        vb_nx = (v_nx >= V_ACT);
        hs_nx = !((h_s >= HS_S + shift_nx) && (h_s < HS_E + shift_nx));
        de_nx = !hb_nx && !vb_nx;

        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        crop_d        = crop_q;
        shift_d       = shift_q;
        hb_d          = hb_q;
        vb_d          = vb_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        de_d          = de_q;
        rgb_d         = rgb_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;

        if (ce_pix) begin
            hcnt_d        = h_nx;
            vcnt_d        = v_nx;
            crop_d        = crop_nx;
            shift_d       = shift_nx;
            hb_d          = hb_nx;
            vb_d          = vb_nx;
            hs_d          = hs_nx;
            vs_d          = !((v_nx >= V_SS) && (v_nx < V_SE));
            de_d          = de_nx;
            rgb_d         = de_nx ? rgb_in : 24'd0;
            line_start_d  = (h_nx == '0);
            frame_start_d = frame_nx;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            crop_q        <= '0;
            shift_q       <= '0;
            hb_q          <= 1'b1;
            vb_q          <= 1'b1;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            crop_q        <= crop_d;
            shift_q       <= shift_d;
            hb_q          <= hb_d;
            vb_q          <= vb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.hcnt        = hcnt_q;
    assign vid.vcnt        = vcnt_q;
    assign vid.hb          = hb_q;
    assign vid.vb          = vb_q;
    assign vid.hs          = hs_q;
    assign vid.vs          = vs_q;
    assign vid.de          = de_q;
    assign vid.rgb_out     = rgb_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_hvgen_param.sv
// Directed bench: default timing, a short-frame copy for frame-boundary
// behaviour, and a tiny-raster copy for the full-crop case.
module tb_hvgen_param;

    logic        clk = 1'b0;
    logic        rst_m = 1'b0, rst_s = 1'b0, rst_a = 1'b0;
    logic        ce_m = 1'b1, ce_s = 1'b1, ce_a = 1'b1;
    logic [3:0]  crop_m = 4'd0, crop_s = 4'd0, crop_a = 4'd15;
    logic [3:0]  shift_m = 4'd0, shift_s = 4'd0, shift_a = 4'd0;
    logic [23:0] rgb_in = 24'h123456;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int s_fs = 0;

    always #5 clk = ~clk;

    hvgen_param_if #(.HCNT_W(9), .VCNT_W(8)) m_if ();
    hvgen_param_if #(.HCNT_W(9), .VCNT_W(8)) s_if ();
    hvgen_param_if #(.HCNT_W(9), .VCNT_W(8)) a_if ();

    hvgen_param u_main (
        .clk_sys(clk), .reset_n(rst_m), .ce_pix(ce_m),
        .crop_left(crop_m), .h_shift(shift_m), .rgb_in(rgb_in),
        .vid(m_if)
    );

    hvgen_param #(
        .V_TOTAL(8), .V_ACTIVE(6), .V_SYNC_START(6), .V_SYNC_END(7)
    ) u_short (
        .clk_sys(clk), .reset_n(rst_s), .ce_pix(ce_s),
        .crop_left(crop_s), .h_shift(shift_s), .rgb_in(rgb_in),
        .vid(s_if)
    );

    hvgen_param #(
        .H_TOTAL(40), .H_ACTIVE(8), .H_SYNC_START(20), .H_SYNC_END(24),
        .V_TOTAL(4), .V_ACTIVE(2), .V_SYNC_START(2), .V_SYNC_END(3)
    ) u_alt (
        .clk_sys(clk), .reset_n(rst_a), .ce_pix(ce_a),
        .crop_left(crop_a), .h_shift(shift_a), .rgb_in(rgb_in),
        .vid(a_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (s_if.frame_start) s_fs++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_m(input int h, input int v, input int maxc);
        int n = 0;
        while (!(int'(m_if.hcnt) == h && int'(m_if.vcnt) == v) && n < maxc) begin
            tick();
            n++;
        end
        chk("reach_m", 32'(int'(m_if.hcnt) == h && int'(m_if.vcnt) == v), 1);
    endtask

    task automatic run_s(input int h, input int v, input int maxc);
        int n = 0;
        while (!(int'(s_if.hcnt) == h && int'(s_if.vcnt) == v) && n < maxc) begin
            tick();
            n++;
        end
        chk("reach_s", 32'(int'(s_if.hcnt) == h && int'(s_if.vcnt) == v), 1);
    endtask

    task automatic chk_rst_m(input string pfx);
        chk({pfx, "_hcnt"}, 32'(m_if.hcnt), 0);
        chk({pfx, "_vcnt"}, 32'(m_if.vcnt), 0);
        chk({pfx, "_hb"}, 32'(m_if.hb), 1);
        chk({pfx, "_vb"}, 32'(m_if.vb), 1);
        chk({pfx, "_hs"}, 32'(m_if.hs), 1);
        chk({pfx, "_vs"}, 32'(m_if.vs), 1);
        chk({pfx, "_de"}, 32'(m_if.de), 0);
        chk({pfx, "_rgb"}, 32'(m_if.rgb_out), 0);
        chk({pfx, "_ls"}, 32'(m_if.line_start), 0);
        chk({pfx, "_fs"}, 32'(m_if.frame_start), 0);
    endtask

    initial begin
        int n;
        int bad;
        int ls_cnt;
        int c0;
        int de_cnt;
        int rgb_cnt;
        int hbl_cnt;
        logic [8:0] prev;

        // Reset state of the default instance
        repeat (3) tick();
        chk_rst_m("rst");

        // First ce after reset
        rst_m = 1'b1;
        tick();
        chk("first_hcnt", 32'(m_if.hcnt), 1);
        chk("first_vcnt", 32'(m_if.vcnt), 0);
        chk("first_hb", 32'(m_if.hb), 0);
        chk("first_de", 32'(m_if.de), 1);
        chk("first_rgb", 32'(m_if.rgb_out), 32'h123456);
        chk("first_ls", 32'(m_if.line_start), 0);

        // Horizontal blank and sync edges
        run_m(255, 0, 400);
        chk("hb_255", 32'(m_if.hb), 0);
        run_m(256, 0, 4);
        chk("hb_256", 32'(m_if.hb), 1);
        chk("de_256", 32'(m_if.de), 0);
        chk("rgb_256", 32'(m_if.rgb_out), 0);
        run_m(282, 0, 40);
        chk("hs_282", 32'(m_if.hs), 1);
        run_m(283, 0, 4);
        chk("hs_283", 32'(m_if.hs), 0);
        run_m(302, 0, 40);
        chk("hs_302", 32'(m_if.hs), 0);
        run_m(303, 0, 4);
        chk("hs_303", 32'(m_if.hs), 1);
        run_m(0, 1, 40);
        chk("ls_line1", 32'(m_if.line_start), 1);
        chk("hb_h0", 32'(m_if.hb), 0);
        chk("fs_line1", 32'(m_if.frame_start), 0);

        // Line length in ce periods
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_if.line_start && n < 400);
        chk("line_len", 32'(n), 318);
        chk("line2_vcnt", 32'(m_if.vcnt), 2);

        // ce_pix 1-in-4: state holds between enables
        ce_m = 1'b0;
        repeat (3) tick();
        chk("hold_hcnt", 32'(m_if.hcnt), 0);
        chk("hold_ls", 32'(m_if.line_start), 1);
        ce_m = 1'b1;
        tick();
        chk("ce_hcnt", 32'(m_if.hcnt), 1);
        chk("ce_ls", 32'(m_if.line_start), 0);
        bad = 0;
        ls_cnt = 0;
        for (int i = 0; i < 318 * 4; i++) begin
            ce_m = (i % 4 == 3);
            prev = m_if.hcnt;
            tick();
            if (!ce_m && m_if.hcnt != prev) bad++;
            if (m_if.line_start) ls_cnt++;
        end
        ce_m = 1'b1;
        chk("ce_nochange", 32'(bad), 0);
        chk("ce_ls_cycles", 32'(ls_cnt), 4);
        chk("ce_end_hcnt", 32'(m_if.hcnt), 1);
        chk("ce_end_vcnt", 32'(m_if.vcnt), 3);

        // Asynchronous reset mid-frame
        run_m(100, 50, 20000);
        #2;
        rst_m = 1'b0;
        #1;
        chk_rst_m("async");
        repeat (2) tick();
        rst_m = 1'b1;
        tick();
        chk("restart_hcnt", 32'(m_if.hcnt), 1);
        chk("restart_vcnt", 32'(m_if.vcnt), 0);
        chk("restart_fs", 32'(m_if.frame_start), 0);
        rst_m = 1'b0;

        // Short-frame instance: vertical timing, crop and shift shadows
        rgb_in = 24'hFFFFFF;
        rst_s = 1'b1;
        c0 = cyc;
        run_s(0, 2, 2000);
        chk("s_hb_f0", 32'(s_if.hb), 0);
        chk("s_de_f0", 32'(s_if.de), 1);
        chk("s_ls_f0", 32'(s_if.line_start), 1);
        chk("s_rgb_f0", 32'(s_if.rgb_out), 32'hFFFFFF);
        crop_s = 4'd5;
        run_s(0, 3, 400);
        chk("s_crop_midframe", 32'(s_if.hb), 0);
        chk("s_rgb_midframe", 32'(s_if.rgb_out), 32'hFFFFFF);
        run_s(317, 5, 1000);
        chk("s_vb_v5", 32'(s_if.vb), 0);
        chk("s_vs_v5end", 32'(s_if.vs), 1);
        run_s(0, 6, 4);
        chk("s_vb_v6", 32'(s_if.vb), 1);
        chk("s_vs_v6", 32'(s_if.vs), 0);
        chk("s_rgb_v6", 32'(s_if.rgb_out), 0);
        run_s(0, 7, 400);
        chk("s_vs_v7", 32'(s_if.vs), 1);
        run_s(317, 7, 400);
        chk("s_no_early_fs", 32'(s_fs), 0);
        run_s(0, 0, 4);
        chk("s_fs", 32'(s_if.frame_start), 1);
        chk("s_frame_len", 32'(cyc - c0), 2544);
        chk("s_crop_h0_hb", 32'(s_if.hb), 1);
        chk("s_crop_h0_rgb", 32'(s_if.rgb_out), 0);
        chk("s_crop_h0_de", 32'(s_if.de), 0);
        run_s(4, 0, 10);
        chk("s_crop_h4_hb", 32'(s_if.hb), 1);
        chk("s_crop_h4_rgb", 32'(s_if.rgb_out), 0);
        run_s(5, 0, 4);
        chk("s_crop_h5_hb", 32'(s_if.hb), 0);
        chk("s_crop_h5_rgb", 32'(s_if.rgb_out), 32'hFFFFFF);

        run_s(282, 1, 800);
        chk("s_hs0_282", 32'(s_if.hs), 1);
        run_s(283, 1, 4);
        chk("s_hs0_283", 32'(s_if.hs), 0);
        shift_s = 4'b1000;
        run_s(302, 1, 40);
        chk("s_hs0_302", 32'(s_if.hs), 0);
        run_s(303, 1, 4);
        chk("s_hs0_303", 32'(s_if.hs), 1);

        run_s(0, 0, 3000);
        run_s(274, 0, 400);
        chk("s_hsm8_274", 32'(s_if.hs), 1);
        run_s(275, 0, 4);
        chk("s_hsm8_275", 32'(s_if.hs), 0);
        run_s(294, 0, 40);
        chk("s_hsm8_294", 32'(s_if.hs), 0);
        run_s(295, 0, 4);
        chk("s_hsm8_295", 32'(s_if.hs), 1);
        shift_s = 4'd7;

        run_s(0, 0, 3000);
        run_s(289, 0, 400);
        chk("s_hsp7_289", 32'(s_if.hs), 1);
        run_s(290, 0, 4);
        chk("s_hsp7_290", 32'(s_if.hs), 0);
        run_s(309, 0, 40);
        chk("s_hsp7_309", 32'(s_if.hs), 0);
        run_s(310, 0, 4);
        chk("s_hsp7_310", 32'(s_if.hs), 1);
        rst_s = 1'b0;

        // Tiny raster with crop beyond the active width
        rst_a = 1'b1;
        de_cnt = 0;
        n = 0;
        do begin
            tick();
            n++;
            if (a_if.de && !a_if.frame_start) de_cnt++;
        end while (!a_if.frame_start && n < 300);
        chk("a_fs_seen", 32'(a_if.frame_start), 1);
        chk("a_f0_de_cnt", 32'(de_cnt), 15);
        de_cnt = 0;
        rgb_cnt = 0;
        hbl_cnt = 0;
        for (int i = 0; i < 160; i++) begin
            tick();
            if (a_if.de) de_cnt++;
            if (a_if.rgb_out != 24'd0) rgb_cnt++;
            if (!a_if.hb) hbl_cnt++;
        end
        chk("a_f1_de_cnt", 32'(de_cnt), 0);
        chk("a_f1_rgb_cnt", 32'(rgb_cnt), 0);
        chk("a_f1_hb_low_cnt", 32'(hbl_cnt), 0);
        rst_a = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hvgen_param.md
HVGEN_PARAM -- requirements
Module: hvgen_param

Interface
REQ-001 H_TOTAL, default 318: pixels per line; hcnt runs 0..H_TOTAL-1.
REQ-002 H_ACTIVE, default 256: first pixel of horizontal blank.
REQ-003 H_SYNC_START / H_SYNC_END, defaults 283 / 303: hs low for hcnt in [START, END).
REQ-004 V_TOTAL, default 256: lines per frame; vcnt runs 0..V_TOTAL-1.
REQ-005 V_ACTIVE, default 240: first line of vertical blank.
REQ-006 V_SYNC_START / V_SYNC_END, defaults 252 / 255: vs low for vcnt in [START, END).
REQ-007 HCNT_W / VCNT_W, defaults 9 / 8: counter widths.
REQ-008 clk_sys  in  1  single clock for all state.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 ce_pix  in  1  pixel clock enable; all state advances only when high.
REQ-011 crop_left  in  4  leading active pixels forced into hblank, 0..15.
REQ-012 h_shift  in  4  signed sync shift, -8..+7 pixels, applied to both sync edges.
REQ-013 rgb_in  in  24  pixel colour {R,G,B}.
REQ-014 rgb_out  out  24  colour, zero whenever blanked.
REQ-015 hcnt / vcnt  out  HCNT_W / VCNT_W  current position.
REQ-016 hb, vb, hs, vs, de  out  1  blanks (high = blank), syncs (low = active), de = ~hb & ~vb.
REQ-017 line_start / frame_start  out  1  one-ce pulses.

Function
REQ-018 The block SHALL increment hcnt on each ce_pix. At H_TOTAL-1 it SHALL wrap hcnt to 0 and advance vcnt. vcnt SHALL wrap from V_TOTAL-1 to 0.
REQ-019 The block SHALL register all outputs. Each output SHALL be decoded from the next counter value, so every flag aligns with the hcnt/vcnt presented on the same cycle; there is zero added latency between counter and flags.
REQ-020 hb SHALL be high iff hcnt < crop_q or hcnt >= H_ACTIVE. crop_q is the shadow copy of crop_left.
REQ-021 vb SHALL be high iff vcnt >= V_ACTIVE.
REQ-022 hs SHALL be low iff hcnt is in [H_SYNC_START+shift_q, H_SYNC_END+shift_q). shift_q is the sign-extended shadow of h_shift. The arithmetic SHALL be at HCNT_W+1 bits so negative shifts do not wrap.
REQ-023 vs SHALL be low iff vcnt is in [V_SYNC_START, V_SYNC_END). vs SHALL change only on ce cycles where hcnt becomes 0.
REQ-024 rgb_out SHALL load rgb_in on the same ce edge that loads the aligned counter value, or 24'd0 if that position is blanked.
REQ-025 line_start SHALL pulse for the ce cycle in which hcnt becomes 0. frame_start SHALL pulse when hcnt and vcnt both become 0.
REQ-026 crop_q and shift_q SHALL load from crop_left and h_shift only on the frame_start edge. Mid-frame input changes SHALL have no effect until the next frame.
REQ-027 When ce_pix is low, all outputs and state SHALL hold. Pulses last exactly one ce period and are not re-asserted on held cycles.
REQ-028 If crop_q >= H_ACTIVE, hb SHALL stay high for the whole line and de SHALL stay low. There is no wrap and no error.
REQ-029 Parameters with H_SYNC_END+7 >= H_TOTAL or H_SYNC_START-8 < H_ACTIVE SHALL be rejected at elaboration. The same SHALL apply to any START >= END.

Reset
REQ-030 While reset_n is low, regardless of clock:
- hcnt = 0, vcnt = 0, crop_q = 0, shift_q = 0
- hb = vb = 1, hs = vs = 1, de = 0
- rgb_out = 0, line_start = frame_start = 0
REQ-031 After reset_n rises, the first ce SHALL produce hcnt = 1 with vcnt = 0. No frame_start SHALL occur until the first full wrap.
REQ-032 Assertion of reset_n mid-line SHALL take effect immediately, without waiting for a clock edge.

Verification
REQ-033 Defaults, ce every cycle, crop_left=0, h_shift=0:
- hb falls at hcnt 0 and rises at 256
- hs is low for hcnt 283..302
- the line is 318 ce long
- vb rises at vcnt 240
- vs is low for vcnt 252..254
REQ-034 crop_left=5 written mid-frame: the current frame keeps hb low from hcnt 0. The next frame holds hb high for hcnt 0..4, and rgb_out = 0 there even with rgb_in = 24'hFFFFFF.
REQ-035 h_shift=-8, then h_shift=+7, each applied over a frame boundary: hs is low for 275..294, then for 290..309.
REQ-036 ce_pix toggled 1-in-4: counters and flags change only on ce cycles, and line_start is high for exactly one ce period.
REQ-037 reset_n pulsed low at hcnt=100, vcnt=50: the reset values of REQ-030 appear without a clock edge. Restart then follows REQ-031.
REQ-038 crop_left=15 with H_ACTIVE=8 (alternate parameter set): de is never asserted, and rgb_out stays 0 for the whole frame.
